// File: rtl/bus_ctrl_pkg.sv
// Shared constants and FSM encoding for the bus transfer controller.
package bus_ctrl_pkg;

   localparam int BUS_W    = 16;
   localparam int NUM_REGS = 4;

   localparam logic [2:0] SRC_IMM = 3'd4;
   localparam logic [2:0] DST_CAP = 3'd4;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_DRIVE = 2'd1;
   localparam logic [1:0] ST_LOAD  = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE  = ST_IDLE,
      S_DRIVE = ST_DRIVE,
      S_LOAD  = ST_LOAD,
      S_DONE  = ST_DONE
   } state_t;

endpackage

// File: rtl/onehot_dec.sv
// Index-to-one-hot decoder; output is all zero when disabled or the index is
// outside the register range.
module onehot_dec #(
   parameter int NUM_REGS = 4
) (
   input  logic [2:0]          idx,
   input  logic                en,
   output logic [NUM_REGS-1:0] onehot
);

   always_comb begin
      onehot = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (en && (int'(idx) == i)) onehot[i] = 1'b1;
      end
   end

endmodule

// File: rtl/bus_xfer_ctrl.sv
// Sequences one register/immediate -> register/capture transfer over a shared
// tristate bus: DRIVE, then LOAD (drive held, load strobe, capture), then DONE.
module bus_xfer_ctrl
   import bus_ctrl_pkg::*;
#(
   parameter int BUS_W    = bus_ctrl_pkg::BUS_W,
   parameter int NUM_REGS = bus_ctrl_pkg::NUM_REGS
) (
   input  logic                clk,
   input  logic                rst,
   // Handshake: a command transfers on an edge where cmd_valid && cmd_ready;
   // the requester holds cmd_* stable until then, and cmd_ready is high only in IDLE.
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [2:0]          cmd_src,
   input  logic [2:0]          cmd_dst,
   input  logic [BUS_W-1:0]    cmd_imm,
   input  logic [BUS_W-1:0]    bus_in,
   output logic [NUM_REGS-1:0] reg_tri_en,
   output logic [NUM_REGS-1:0] reg_ld_en,
   output logic [BUS_W-1:0]    imm_to_bus,
   output logic                imm_tri_en,
   output logic [BUS_W-1:0]    cap_data,
   output logic                done,
   output logic                err,
   output logic [1:0]          fsm_state
);

   state_t           state;
   logic [2:0]       src_q;
   logic [2:0]       dst_q;
   logic [BUS_W-1:0] imm_q;
   logic             legal;
   logic             drive_act;

   assign legal = (cmd_src <= SRC_IMM) && (cmd_dst <= DST_CAP);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         src_q    <= '0;
         dst_q    <= '0;
         imm_q    <= '0;
         cap_data <= '0;
         err      <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  src_q <= cmd_src;
                  dst_q <= cmd_dst;
                  imm_q <= cmd_imm;
                  if (legal) state <= S_DRIVE;
                  else       err   <= 1'b1;
               end
            end
            S_DRIVE: state <= S_LOAD;
            S_LOAD: begin
               cap_data <= bus_in;
               state    <= S_DONE;
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Drive enables are decoded from state so a reset edge clears them at once.
   assign drive_act  = (state == S_DRIVE) || (state == S_LOAD);
   assign imm_tri_en = drive_act && (src_q == SRC_IMM);
   assign imm_to_bus = imm_tri_en ? imm_q : '0;
   assign cmd_ready  = (state == S_IDLE);
   assign done       = (state == S_DONE);
   assign fsm_state  = state;

   onehot_dec #(.NUM_REGS(NUM_REGS)) u_src_dec (
      .idx    (src_q),
      .en     (drive_act),
      .onehot (reg_tri_en)
   );

   onehot_dec #(.NUM_REGS(NUM_REGS)) u_dst_dec (
      .idx    (dst_q),
      .en     (state == S_LOAD),
      .onehot (reg_ld_en)
   );

endmodule
